// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution datapath.
package conv_pkg;

    localparam int FMS_PATCH_SIZE    = 8;
    localparam int KERNEL_SIZE       = 3;
    localparam int IN_DATA_WIDTH     = 8;
    localparam int KERNEL_DATA_WIDTH = 4;
    localparam int CORE_NUM          = 2;
    // Accumulator width of one core result: pixel * weight summed over the kernel window.
    localparam int OUT_DATA_WIDTH    = IN_DATA_WIDTH + KERNEL_DATA_WIDTH +
                                       $clog2(2 * KERNEL_SIZE * KERNEL_SIZE);

    typedef enum logic {IDLE, STREAM} state_e;

endpackage

// File: rtl/conv_pix_requant.sv
// Per-pixel requantiser: arithmetic right shift, then clamp to the output width.
module conv_pix_requant #(
    parameter int IN_DATA_WIDTH = 17,
    parameter int OUT_PIX_WIDTH = 8,
    parameter int SHIFT         = 0,
    parameter bit SIGNED_OUT    = 1'b1
) (
    input  logic [IN_DATA_WIDTH-1:0] din,
    output logic [OUT_PIX_WIDTH-1:0] dout,
    output logic                     sat
);

    // One guard bit so the unsigned upper bound is representable as a positive signed value.
    localparam int EW = IN_DATA_WIDTH + 1;

    localparam logic signed [EW-1:0] S_MAX = {{(EW-OUT_PIX_WIDTH+1){1'b0}},
                                              {(OUT_PIX_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] S_MIN = {{(EW-OUT_PIX_WIDTH+1){1'b1}},
                                              {(OUT_PIX_WIDTH-1){1'b0}}};
    localparam logic signed [EW-1:0] U_MAX = {{(EW-OUT_PIX_WIDTH){1'b0}},
                                              {OUT_PIX_WIDTH{1'b1}}};

    logic signed [EW-1:0] shifted;

    always_comb begin
        shifted = $signed({din[IN_DATA_WIDTH-1], din}) >>> SHIFT;
        dout    = shifted[OUT_PIX_WIDTH-1:0];
        sat     = 1'b0;
        if (SIGNED_OUT) begin
            if (shifted > S_MAX) begin
                dout = S_MAX[OUT_PIX_WIDTH-1:0];
                sat  = 1'b1;
            end else if (shifted < S_MIN) begin
                dout = S_MIN[OUT_PIX_WIDTH-1:0];
                sat  = 1'b1;
            end
        end else begin
            if (shifted < 0) begin
                dout = '0;
                sat  = 1'b1;
            end else if (shifted > U_MAX) begin
                dout = '1;
                sat  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_out_serializer.sv
// Captures a full parallel output patch and streams it out one requantised pixel per beat,
// raster order, reloading on the final handshake so consecutive patches have no bubble.
module conv_out_serializer #(
    parameter int FMS_PATCH_SIZE = conv_pkg::FMS_PATCH_SIZE,
    parameter int IN_DATA_WIDTH  = conv_pkg::OUT_DATA_WIDTH,
    parameter int OUT_PIX_WIDTH  = 8,
    parameter int SHIFT          = 0,
    parameter bit SIGNED_OUT     = 1'b1
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [FMS_PATCH_SIZE*FMS_PATCH_SIZE*IN_DATA_WIDTH-1:0] patch_in,
    input  logic                                                   patch_vld,
    output logic                                                   patch_rdy,
    output logic [OUT_PIX_WIDTH-1:0]                               pix_data,
    output logic                                                   pix_vld,
    input  logic                                                   pix_rdy,
    output logic                                                   pix_eol,
    output logic                                                   pix_last,
    output logic                                                   pix_sat,
    output logic                                                   busy
);

    import conv_pkg::*;

    localparam int NPIX  = FMS_PATCH_SIZE * FMS_PATCH_SIZE;
    localparam int IDX_W = $clog2(NPIX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    state_e                          state_q;
    logic [IDX_W-1:0]                idx_q;
    logic [NPIX*IN_DATA_WIDTH-1:0]   buf_q;

    logic                            streaming;
    logic                            last_beat;
    logic                            pix_fire;
    logic                            load;
    logic [IN_DATA_WIDTH-1:0]        cur_pix;
    logic [OUT_PIX_WIDTH-1:0]        rq_data;
    logic                            rq_sat;

    always_comb begin
        streaming = (state_q == STREAM);
        last_beat = streaming && (idx_q == LAST_IDX);
        pix_fire  = streaming && pix_rdy;
        // Ready opens in IDLE, or on the final beat only when that beat is being consumed.
        patch_rdy = !streaming || (last_beat && pix_rdy);
        load      = patch_vld && patch_rdy;
        cur_pix   = buf_q[int'(idx_q)*IN_DATA_WIDTH +: IN_DATA_WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            if (load) begin
                buf_q   <= patch_in;
                idx_q   <= '0;
                state_q <= STREAM;
            end else if (pix_fire) begin
                if (last_beat) begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    conv_pix_requant #(
        .IN_DATA_WIDTH (IN_DATA_WIDTH),
        .OUT_PIX_WIDTH (OUT_PIX_WIDTH),
        .SHIFT         (SHIFT),
        .SIGNED_OUT    (SIGNED_OUT)
    ) u_requant (
        .din  (cur_pix),
        .dout (rq_data),
        .sat  (rq_sat)
    );

    always_comb begin
        pix_vld  = streaming;
        busy     = streaming;
        pix_data = streaming ? rq_data : '0;
        pix_sat  = streaming && rq_sat;
        pix_eol  = streaming && ((int'(idx_q) % FMS_PATCH_SIZE) == FMS_PATCH_SIZE - 1);
        pix_last = last_beat;
    end

endmodule

// File: doc/conv_out_serializer.md
Name: conv_out_serializer

Overview:
Back-end of the convolution datapath. Captures one full parallel output patch from the convolution core (FMS_PATCH_SIZE² results, packed flat vector) and streams it out one pixel per beat in raster order over a valid/ready interface. Each pixel is arithmetically shifted and clamped to the output pixel width. A double-use capture point lets a new patch load on the same cycle the last pixel is accepted, so consecutive patches stream with no bubble.

Parameters:
FMS_PATCH_SIZE, 8, patch edge length N; N*N pixels per patch
IN_DATA_WIDTH, 17, width of each packed core result (8+4+$clog2(18))
OUT_PIX_WIDTH, 8, streamed pixel width
SHIFT, 0, arithmetic right shift applied before clamping (0..IN_DATA_WIDTH-1)
SIGNED_OUT, 1, 1 = clamp to signed OUT_PIX_WIDTH range; 0 = clamp to [0, 2^OUT_PIX_WIDTH-1]

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
patch_in  in  N*N*IN_DATA_WIDTH  packed signed results; pixel i at [(i+1)*IN_DATA_WIDTH-1 -: IN_DATA_WIDTH]
patch_vld  in  1  patch_in valid
patch_rdy  out  1  serializer can accept a patch this cycle
pix_data  out  OUT_PIX_WIDTH  requantised pixel
pix_vld  out  1  pix_data valid
pix_rdy  in  1  downstream accepts pixel
pix_eol  out  1  current pixel is last in its row (i%N == N-1)
pix_last  out  1  current pixel is last of patch (i == N*N-1)
pix_sat  out  1  current pixel was clamped
busy  out  1  in STREAM state

Behaviour:
- Reset (async, rst=1): state IDLE, idx=0, buffer cleared; pix_vld=0, pix_data=0, pix_eol=0, pix_last=0, pix_sat=0, busy=0, patch_rdy=1 once rst deasserted. Reset mid-stream discards the patch immediately; no partial resume.
- FSM IDLE: patch_rdy=1. patch_vld=1 at edge E captures patch_in into buffer, idx=0, go STREAM. First pixel is valid in the cycle after E (1-cycle latency).
- FSM STREAM: pix_vld=1, busy=1. pix_vld&pix_rdy at an edge advances idx by 1.
- Last beat (idx=N*N-1): patch_rdy = pix_rdy (combinational). On that handshake: if patch_vld, capture the new patch, idx=0, stay STREAM (next beat is pixel 0 of the new patch, no bubble); else go IDLE, pix_vld=0.
- Outside the last beat in STREAM, patch_rdy=0; patch_vld is ignored and patch_in is not sampled.
- While pix_vld=1 and pix_rdy=0, pix_data/pix_eol/pix_last/pix_sat hold stable.
- Sidebands are decoded from idx: pix_eol when idx%N==N-1; pix_last when idx==N*N-1. All are 0 when pix_vld=0.
- Requantise: t = buffer[idx] >>> SHIFT (sign-preserving). SIGNED_OUT=1: clamp to [-2^(W-1), 2^(W-1)-1]. SIGNED_OUT=0: clamp to [0, 2^W-1]. W=OUT_PIX_WIDTH. pix_sat=1 iff the clamp changed the value.
- idx width is $clog2(N*N). It never wraps except through the last-beat reload.

Decomposition:
- Shared package conv_pkg holds FMS_PATCH_SIZE, KERNEL_SIZE, IN/KERNEL data widths, CORE_NUM, the derived OUT_DATA_WIDTH constant, and the state enum typedef {IDLE, STREAM}.
- One combinational sub-module, conv_pix_requant (shift + clamp + sat flag), parameterised by IN_DATA_WIDTH, OUT_PIX_WIDTH, SHIFT, SIGNED_OUT. It is reused by later per-pixel post-processing blocks.

Test Plan:
1. Reset: assert rst for 2 cycles mid-idle -> pix_vld=0, pix_data=0, busy=0; after release patch_rdy=1.
2. Raster order: patch with pixel i=i, pix_rdy=1 held -> 64 beats with values 0..63 on consecutive cycles, starting the cycle after accept. pix_eol on 7,15,…,63; pix_last only on 63; then pix_vld=0 and patch_rdy=1.
3. Clamp: pixels 0..2 = 300, -200, -1. With SIGNED_OUT=1 -> 127 (sat), -128 (sat), -1 (no sat). With SIGNED_OUT=0 -> 255 (sat), 0 (sat), 0 (sat). With SHIFT=2, SIGNED_OUT=1 -> 75, -50, -1, no sat.
4. Backpressure: drop pix_rdy for 5 cycles while idx=10 -> pix_data stays 10 for all 5 cycles; stream resumes at 10, then 11, with no skipped or duplicated pixel.
5. Back-to-back: patch A (i) and patch B (100+i). Hold patch_vld=1 with B during A's stream -> patch_rdy=0 until A's beat 63 handshake. B's pixel 0 (value 100) appears the very next cycle with no pix_vld gap.
6. Reset mid-stream at idx=30 -> pix_vld drops with no clock edge required. The next patch (pixel i = 2i) streams from pixel 0 (value 0).
